// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bundle for the pipelined add/sub unit
interface cla_addsub_pipe_if #(parameter int WIDTH = 15);
  logic in_valid, in_ready, sub, sat, out_valid, out_ready, c_out, v_out, ovf_sticky, ovf_clr;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, sub, sat, a, b, out_ready, ovf_clr,
    input  in_ready, out_valid, sum, c_out, v_out, ovf_sticky
  );
  modport slave (
    input  in_valid, sub, sat, a, b, out_ready, ovf_clr,
    output in_ready, out_valid, sum, c_out, v_out, ovf_sticky
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined signed add/subtract with segmented carry-lookahead, saturation and sticky overflow
module cla_addsub_pipe #(
  parameter int WIDTH = 15,
  parameter int GROUP = 3,
  parameter int STAGES = 5
) (
  input logic clk,
  input logic rst_n,
  cla_addsub_pipe_if.slave io
);
  localparam int SEG = WIDTH / STAGES;
  localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;
  if (WIDTH % STAGES != 0 || SEG % GROUP != 0) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must split into STAGES segments made of whole GROUPs");
  end
  // lookahead within each group, ripple of the group carry into the next group
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                               input logic cin);
    logic [SEG-1:0] g, p;
    logic [SEG:0] c;
    logic t, u;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = cin;
    for (int q = 0; q < SEG; q += GROUP)
      for (int j = 1; j <= GROUP; j++) begin
        t = c[q];
        for (int m = 0; m < j; m++) t = t & p[q+m];
        for (int m = 0; m < j; m++) begin
          u = g[q+m];
          for (int n = m + 1; n < j; n++) u = u & p[q+n];
          t = t | u;
        end
        c[q+j] = t;
      end
    return c;
  endfunction
  logic adv, v_n, v_d, v_q, ovf_d, ovf_q;
  logic [STAGES-1:0] vld_s, vld_d, vld_q, c_s, c_n, c_d, c_q, sub_s, sat_s;
  logic [OPS-1:0] sub_d, sub_q, sat_d, sat_q;
  logic [WIDTH-1:0] a_s [STAGES], b_s [STAGES], r_s [STAGES], r_n [STAGES], r_d [STAGES], r_q [STAGES];
  logic [WIDTH-1:0] a_d [OPS], a_q [OPS], b_d [OPS], b_q [OPS];
  logic [WIDTH-1:0] y;
  logic [SEG:0] cc;
  always_comb begin
    adv = io.out_ready | ~vld_q[STAGES-1];
    a_s[0] = io.a;
    b_s[0] = io.b;
    r_s[0] = '0;
    c_s[0] = io.sub;
    vld_s[0] = io.in_valid;
    sub_s[0] = io.sub;
    sat_s[0] = io.sat;
    for (int k = 1; k < STAGES; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      r_s[k] = r_q[k-1];
      c_s[k] = c_q[k-1];
      vld_s[k] = vld_q[k-1];
      sub_s[k] = sub_q[k-1];
      sat_s[k] = sat_q[k-1];
    end
    y = '0;
    cc = '0;
    for (int k = 0; k < STAGES; k++) begin
      y = b_s[k] ^ {WIDTH{sub_s[k]}};
      cc = cla_carries(a_s[k][k*SEG +: SEG], y[k*SEG +: SEG], c_s[k]);
      r_n[k] = r_s[k];
      r_n[k][k*SEG +: SEG] = a_s[k][k*SEG +: SEG] ^ y[k*SEG +: SEG] ^ cc[SEG-1:0];
      c_n[k] = cc[SEG];
    end
    // cc now holds the top segment's carries
    v_n = cc[SEG] ^ cc[SEG-1];
    r_n[STAGES-1] = (sat_s[STAGES-1] & v_n)
                  ? {a_s[STAGES-1][WIDTH-1], {(WIDTH-1){~a_s[STAGES-1][WIDTH-1]}}} : r_n[STAGES-1];
    vld_d = adv ? vld_s : vld_q;
    c_d = adv ? c_n : c_q;
    v_d = adv ? v_n : v_q;
    for (int k = 0; k < STAGES; k++) r_d[k] = adv ? r_n[k] : r_q[k];
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    sat_d = sat_q;
    for (int k = 0; k < STAGES - 1; k++) begin
      a_d[k] = adv ? a_s[k] : a_q[k];
      b_d[k] = adv ? b_s[k] : b_q[k];
      sub_d[k] = adv ? sub_s[k] : sub_q[k];
      sat_d[k] = adv ? sat_s[k] : sat_q[k];
    end
    ovf_d = (adv & vld_s[STAGES-1] & v_n) | (ovf_q & ~io.ovf_clr);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q <= '0;
      v_q <= 1'b0;
      ovf_q <= 1'b0;
      sub_q <= '0;
      sat_q <= '0;
      r_q <= '{default: '0};
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      c_q <= c_d;
      v_q <= v_d;
      ovf_q <= ovf_d;
      sub_q <= sub_d;
      sat_q <= sat_d;
      r_q <= r_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign io.in_ready = adv;
  assign io.out_valid = vld_q[STAGES-1];
  assign io.sum = r_q[STAGES-1];
  assign io.c_out = c_q[STAGES-1];
  assign io.v_out = v_q;
  assign io.ovf_sticky = ovf_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: table, hand-written and random checks against an integer reference model
module tb_cla_addsub_pipe;
  localparam int W = 15, S = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  cla_addsub_pipe_if #(.WIDTH(W)) io();
  cla_addsub_pipe_if #(.WIDTH(32)) io2();
  cla_addsub_pipe #(.WIDTH(W), .GROUP(3), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .io(io2));
  typedef struct {
    logic sub;
    logic sat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic c;
    logic v;
    int acc;
  } vec_t;
  int checks = 0, errors = 0, cyc = 0;
  bit chk_lat = 0, rdone = 0;
  vec_t q[$];
  logic held = 1'b0, hc, hv;
  logic [W-1:0] hsum;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic vec_t tv(input logic s, input logic st, input int a, input int b, input int sum,
                              input logic c, input logic v);
    vec_t e;
    e.sub = s; e.sat = st; e.a = W'(a); e.b = W'(b); e.sum = W'(sum); e.c = c; e.v = v; e.acc = 0;
    return e;
  endfunction
  function automatic vec_t model(input logic s, input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t e;
    longint sa, sb, r, u, mx;
    logic [W-1:0] nb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = s ? sa - sb : sa + sb;
    mx = (longint'(1) <<< (W - 1)) - 1;
    nb = ~b;
    u = longint'(a) + (s ? longint'(nb) + 1 : longint'(b));
    e.sub = s; e.sat = st; e.a = a; e.b = b;
    e.v = (r > mx) || (r < -mx - 1);
    e.c = u[W];
    e.sum = (st && e.v) ? ((r > 0) ? W'(mx) : W'(-mx - 1)) : W'(r);
    e.acc = 0;
    return e;
  endfunction
  function automatic vec_t rnd();
    return model(1'($urandom_range(1)), 1'($urandom_range(1)), W'($urandom), W'($urandom));
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    vec_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held && io.out_valid) begin
        chk("hold_sum", io.sum, hsum);
        chk("hold_c_out", io.c_out, hc);
        chk("hold_v_out", io.v_out, hv);
      end
      held = io.out_valid && !io.out_ready;
      hsum = io.sum; hc = io.c_out; hv = io.v_out;
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out got beat sum=0x%0h expected no beat", io.sum);
        end else begin
          e = q.pop_front();
          chk("sum", io.sum, e.sum);
          chk("c_out", io.c_out, e.c);
          chk("v_out", io.v_out, e.v);
          if (chk_lat) chk("latency", cyc - e.acc, S);
        end
      end
    end
  end
  task automatic send(input vec_t e);
    int n;
    io.in_valid = 1'b1; io.sub = e.sub; io.sat = e.sat; io.a = e.a; io.b = e.b;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=0 expected 1");
    end else begin
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    io.out_ready = 1'b1;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic send2(input logic s, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sum, input logic c, input logic v);
    io2.sub = s; io2.sat = st; io2.a = a; io2.b = b; io2.in_valid = 1'b1;
    @(posedge clk); #1;
    io2.in_valid = 1'b0;
    @(negedge clk);
    chk("w32_lat1_valid", io2.out_valid, 0);
    @(negedge clk);
    chk("w32_lat2_valid", io2.out_valid, 1);
    chk("w32_sum", io2.sum, sum);
    chk("w32_c_out", io2.c_out, c);
    chk("w32_v_out", io2.v_out, v);
    @(posedge clk); #1;
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[12];
    io.in_valid = 0; io.sub = 0; io.sat = 0; io.a = '0; io.b = '0; io.out_ready = 1; io.ovf_clr = 0;
    io2.in_valid = 0; io2.sub = 0; io2.sat = 0; io2.a = '0; io2.b = '0; io2.out_ready = 1; io2.ovf_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_sum", io.sum, 0);
    chk("rst_c_out", io.c_out, 0);
    chk("rst_v_out", io.v_out, 0);
    chk("rst_ovf_sticky", io.ovf_sticky, 0);
    chk("rst_w32_out_valid", io2.out_valid, 0);
    @(posedge clk); #1;
    tbl[0]  = tv(0, 0, 16, 2, 18, 0, 0);
    tbl[1]  = tv(0, 0, 17, -3, 14, 1, 0);
    tbl[2]  = tv(0, 0, -18, -4, -22, 1, 0);
    tbl[3]  = tv(1, 0, 1000, 1000, 0, 1, 0);
    tbl[4]  = tv(1, 0, -10, 4, -14, 1, 0);
    tbl[5]  = tv(1, 0, 900, -100, 1000, 0, 0);
    tbl[6]  = tv(0, 0, 9000, 8000, -15768, 0, 1);
    tbl[7]  = tv(0, 1, 9000, 8000, 16383, 0, 1);
    tbl[8]  = tv(1, 1, -15000, 3000, -16384, 1, 1);
    tbl[9]  = tv(1, 0, 0, -16384, -16384, 0, 1);
    tbl[10] = tv(1, 1, -1, -16384, 16383, 1, 0);
    tbl[11] = tv(1, 1, 5, -16384, 16383, 0, 1);
    chk_lat = 1;
    for (int i = 0; i < 12; i++) send(tbl[i]);
    drain();
    chk_lat = 0;
    chk("sticky_after_ovf", io.ovf_sticky, 1);
    io.ovf_clr = 1'b1;
    @(posedge clk); #1;
    io.ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_alone", io.ovf_sticky, 0);
    @(posedge clk); #1;
    send(model(0, 0, W'(9000), W'(8000)));
    repeat (S - 2) @(posedge clk);
    #1 io.ovf_clr = 1'b1;
    @(posedge clk); #1;
    io.ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins_valid", io.out_valid, 1);
    chk("sticky_set_wins", io.ovf_sticky, 1);
    drain();
    fork
      for (int i = 0; i < 8; i++) send(rnd());
      begin
        repeat (6) @(posedge clk);
        #1 io.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", io.in_ready, 0);
        end
        @(posedge clk); #1;
        io.out_ready = 1'b1;
      end
    join
    drain();
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send(rnd());
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          io.out_ready = ($urandom_range(3) != 0);
        end
        io.out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(rnd());
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i <= S; i++) begin
      @(negedge clk);
      chk("rst_flush_valid", io.out_valid, 0);
      if (i == 0) chk("rst_flush_sticky", io.ovf_sticky, 0);
    end
    @(posedge clk); #1;
    send2(0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    send2(0, 1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1);
    send2(1, 0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined signed add/subtract unit built from carry-lookahead groups; successor to the fixed-width 15-bit combinational CLA adder/subtractor.
- Adds per-transaction mode (add/sub), optional saturation, a valid/ready handshake with backpressure, a configurable pipeline depth and a sticky overflow flag.
- Sits between operand source and result sink in the ALU datapath.

Parameters:
- WIDTH, 15: operand/result width in bits, two's complement.
- GROUP, 3: CLA group size in bits; carries are generated by lookahead inside each group and rippled between groups.
- STAGES, 5: pipeline register stages. WIDTH % STAGES == 0 and (WIDTH/STAGES) % GROUP == 0 are required; elaboration fails otherwise.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- sub  in  1  0 = A+B, 1 = A-B (B inverted, carry-in 1)
- sat  in  1  1 = clamp result on signed overflow
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- sum  out  WIDTH  result
- c_out  out  1  raw carry out of MSB (for sub: 1 = no borrow)
- v_out  out  1  signed overflow of this result
- ovf_sticky  out  1  set on any overflowed result until cleared
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits 0, out_valid=0, sum=0, c_out=0, v_out=0, ovf_sticky=0. In-flight beats are discarded; no partial results emerge after reset.
- Segmentation: operand split into STAGES segments of WIDTH/STAGES bits. Stage k computes segment k from its carry-in (the registered carry of stage k-1, or sub for stage 0); higher segments and sub/sat are delayed alongside; lower result bits are carried forward.
- Advance rule: adv = out_ready | ~out_valid. in_ready = adv. When adv=1 the whole pipeline shifts one stage and a beat is accepted if in_valid=1; otherwise a bubble (valid=0) enters. When adv=0 all stages hold.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stalls; throughput one beat per cycle.
- Output holds sum/c_out/v_out stable while out_valid=1 and out_ready=0.
- Overflow: v_out = carry into MSB XOR carry out of MSB, using effective B (b or ~b).
- Saturation (sat=1 and v_out=1): sum = 2^(WIDTH-1)-1 if a[MSB]=0, else -2^(WIDTH-1). c_out and v_out report raw values. sat=0: wrapped result.
- Sub with b = -2^(WIDTH-1) follows the same rules (overflow when a >= 0).
- ovf_sticky: set on the cycle a valid beat with overflow loads into the output register. ovf_clr=1 clears it. If both happen on the same cycle, set wins.
- No X propagation: bubbles carry data but valid=0. Sink ignores data when out_valid=0.

Test Plan:
- Defaults, out_ready=1: a=16,b=2,sub=0 then a=17,b=-3, a=-18,b=-4 on consecutive cycles -> out_valid from cycle 5, sums 18, 14, -22 back-to-back, v_out=0.
- sub=1: 1000-1000 -> sum=0, c_out=1; -10-4 -> sum=-14, v_out=0; 900-(-100) -> 1000.
- Overflow wrap: sat=0, 9000+8000 -> sum=-15768, v_out=1, ovf_sticky=1 next cycle. Sat: sat=1, 9000+8000 -> 16383. sat=1, sub=1, -15000-3000 -> -16384, v_out=1.
- Backpressure: stream 8 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, no beat lost or duplicated, order preserved, held output stable.
- Sticky: ovf_clr=1 on the same cycle a second overflowed result loads -> ovf_sticky stays 1. ovf_clr alone -> 0.
- Reset mid-stream with 3 beats in flight -> out_valid=0 the next cycle and for the next STAGES cycles. Also WIDTH=32, GROUP=4, STAGES=2: 0x7FFFFFFF+1 -> 0x80000000, v_out=1, latency 2.
